ps2_key_decoder: RTL and testbench

Receives the PS/2 keyboard serial stream and turns Set-2 scan codes into the level-valued key signals the game logic consumes: UP, DOWN, LEFT, RIGHT, Escape, Start, Pause, Resume. Each output is high while its key is held and low after release. The block sits between the board's PS/2 pins and the game controller. It also exposes the raw byte stream for debug.

---
 rtl/ps2_key_decoder.sv | 151 +++++++++++++++
 tb/tb_ps2_key_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 Set-2 frame receiver and game-key decoder with level outputs
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic       UP,
    output logic       DOWN,
    output logic       LEFT,
    output logic       RIGHT,
    output logic       Escape,
    output logic       Start,
    output logic       Pause,
    output logic       Resume,
    output logic [7:0] SCAN_CODE,
    output logic       SCAN_VALID,
    output logic       FRAME_ERR
);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam logic [19:0] TMO = 20'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  pclk_q, pclk_d;
    logic [1:0]  pdat_q, pdat_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        par_q, par_d;
    logic [19:0] tmo_q, tmo_d;
    logic        ext_q, ext_d;
    logic        brk_q, brk_d;
    logic [7:0]  keys_q, keys_d;
    logic [7:0]  code_q, code_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        fall, din, frame_ok, frame_bad;
    logic [7:0]  hit;

    assign fall = pclk_q[2] & ~pclk_q[1];
    assign din  = pdat_q[1];

    // key bit order: UP, DOWN, LEFT, RIGHT, Escape, Start, Pause, Resume
    assign hit[0] =  ext_q && shift_q == 8'h75;
    assign hit[1] =  ext_q && shift_q == 8'h72;
    assign hit[2] =  ext_q && shift_q == 8'h6B;
    assign hit[3] =  ext_q && shift_q == 8'h74;
    assign hit[4] = !ext_q && shift_q == 8'h76;
    assign hit[5] = !ext_q && shift_q == 8'h5A;
    assign hit[6] = !ext_q && shift_q == 8'h4D;
    assign hit[7] = !ext_q && shift_q == 8'h2D;

    assign {Resume, Pause, Start, Escape, RIGHT, LEFT, DOWN, UP} = keys_q;
    assign SCAN_CODE  = code_q;
    assign SCAN_VALID = valid_q;
    assign FRAME_ERR  = err_q;

    // Synchroniser shift, frame FSM with timeout, and byte decode on stop-bit edge
    always_comb begin
        pclk_d    = {pclk_q[1:0], PS2_CLK};
        pdat_d    = {pdat_q[0], PS2_DATA};
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        par_d     = par_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        keys_d    = keys_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        tmo_d     = (state_q == IDLE || fall) ? '0 : (&tmo_q ? tmo_q : tmo_q + 20'd1);
        if (fall) begin
            case (state_q)
                IDLE: begin
                    state_d = din ? IDLE : DATA;
                    cnt_d   = din ? cnt_q : 4'd0;
                end
                DATA: begin
                    shift_d = {din, shift_q[7:1]};
                    cnt_d   = cnt_q + 4'd1;
                    state_d = (cnt_q == 4'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_d   = din;
                    state_d = STOP;
                end
                STOP: begin
                    state_d   = IDLE;
                    frame_ok  = din && ^{shift_q, par_q};
                    frame_bad = !(din && ^{shift_q, par_q});
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && tmo_q == TMO) begin
            state_d   = IDLE;
            shift_d   = '0;
            cnt_d     = '0;
            frame_bad = 1'b1;
        end
        if (frame_ok) begin
            code_d  = shift_q;
            valid_d = 1'b1;
            ext_d   = (shift_q == 8'hE0) ? 1'b1 : ((shift_q == 8'hF0) ? ext_q : 1'b0);
            brk_d   = (shift_q == 8'hF0) ? 1'b1 : ((shift_q == 8'hE0) ? brk_q : 1'b0);
            keys_d  = (shift_q == 8'hE0 || shift_q == 8'hF0) ? keys_q
                    : (brk_q ? (keys_q & ~hit) : (keys_q | hit));
        end
        if (frame_bad) begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
    end

    // State register; synchroniser resets to the PS/2 idle level
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            pclk_q  <= '1;
            pdat_q  <= '1;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            tmo_q   <= '0;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            keys_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pclk_q  <= pclk_d;
            pdat_q  <= pdat_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            tmo_q   <= tmo_d;
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            keys_q  <= keys_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: randomized PS/2 frames checked against a key-table reference model
module tb_ps2_key_decoder;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst, ps2_clk, ps2_data;
    logic       up, down, left, right, esc, start, pause, resume;
    logic [7:0] scan_code;
    logic       scan_valid, frame_err;

    ps2_key_decoder #(.TIMEOUT_CYCLES(100)) dut (
        .CLK(clk), .RST(rst), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
        .UP(up), .DOWN(down), .LEFT(left), .RIGHT(right),
        .Escape(esc), .Start(start), .Pause(pause), .Resume(resume),
        .SCAN_CODE(scan_code), .SCAN_VALID(scan_valid), .FRAME_ERR(frame_err)
    );

    always #5 clk = ~clk;

    wire [7:0] keys = {resume, pause, start, esc, right, left, down, up};

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // pulse monitor
    int cyc = 0, sv_cnt = 0, fe_cnt = 0, both_cnt = 0, wide_cnt = 0, stray_cnt = 0;
    int last_fe_cyc = 0, last_fall_cyc = 0;
    logic sv_prev = 1'b0, fe_prev = 1'b0, rst_prev = 1'b1;
    logic [7:0] keys_prev = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst && !rst_prev) begin
            if (scan_valid) sv_cnt++;
            if (frame_err) begin
                fe_cnt++;
                last_fe_cyc = cyc;
            end
            if (scan_valid && frame_err) both_cnt++;
            if ((scan_valid && sv_prev) || (frame_err && fe_prev)) wide_cnt++;
            if (keys !== keys_prev && !scan_valid) stray_cnt++;
        end
        sv_prev   = scan_valid;
        fe_prev   = frame_err;
        rst_prev  = rst;
        keys_prev = keys;
    end

    // reference model state
    logic [7:0] m_keys = '0;
    logic [7:0] m_code = '0;
    bit         m_ext = 0, m_brk = 0;

    function automatic int key_idx(input bit e, input logic [7:0] c);
        if (e) begin
            case (c)
                8'h75: return 0;
                8'h72: return 1;
                8'h6B: return 2;
                8'h74: return 3;
                default: return -1;
            endcase
        end
        case (c)
            8'h76: return 4;
            8'h5A: return 5;
            8'h4D: return 6;
            8'h2D: return 7;
            default: return -1;
        endcase
    endfunction

    task automatic model_byte(input logic [7:0] b, input bit ok);
        int k;
        if (!ok) begin
            m_ext = 0;
            m_brk = 0;
            return;
        end
        m_code = b;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            k = key_idx(m_ext, b);
            if (k >= 0) m_keys[k] = !m_brk;
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bp, input bit bs);
        return {~bs, (~^b) ^ bp, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            ps2_data = bits[i];
            tick(HALF);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            tick(HALF);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic xfer(input logic [7:0] b, input bit bp, input bit bs);
        int sv0, fe0;
        bit ok;
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        ok  = !bp && !bs;
        send_bits(frame_bits(b, bp, bs), 0, 11);
        ps2_data = 1'b1;
        tick(HALF);
        model_byte(b, ok);
        chk($sformatf("sv_pulses[%h]", b), sv_cnt - sv0, ok ? 1 : 0);
        chk($sformatf("fe_pulses[%h]", b), fe_cnt - fe0, ok ? 0 : 1);
        chk($sformatf("keys[%h]", b), keys, m_keys);
        chk($sformatf("code[%h]", b), scan_code, m_code);
    endtask

    initial begin
        int sv0, fe0, d;
        logic [7:0] pool [10] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h76, 8'h5A, 8'h4D, 8'h2D};
        logic [7:0] b;
        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        tick(4);
        chk("reset_keys", keys, 0);
        chk("reset_code", scan_code, 0);
        chk("reset_pulses", {scan_valid, frame_err}, 0);
        rst = 1'b0;
        tick(4);

        xfer(8'h76, 0, 0);
        xfer(8'hF0, 0, 0);
        xfer(8'h76, 0, 0);

        xfer(8'hE0, 0, 0); xfer(8'h75, 0, 0);
        xfer(8'hE0, 0, 0); xfer(8'h6B, 0, 0);
        xfer(8'hE0, 0, 0); xfer(8'hF0, 0, 0); xfer(8'h75, 0, 0);

        xfer(8'h5A, 1, 0);
        xfer(8'h5A, 0, 0);

        sv0 = sv_cnt;
        fe0 = fe_cnt;
        send_bits(frame_bits(8'h4D, 0, 0), 0, 4);
        tick(150);
        model_byte(8'h00, 0);
        d = last_fe_cyc - last_fall_cyc;
        chk("timeout_fe", fe_cnt - fe0, 1);
        chk("timeout_sv", sv_cnt - sv0, 0);
        chk("timeout_latency", (d >= 100 && d <= 108), 1);
        xfer(8'h4D, 0, 0);

        xfer(8'hE0, 0, 0);
        xfer(8'h12, 0, 1);
        xfer(8'h5A, 0, 0);
        xfer(8'hE0, 0, 0);
        xfer(8'h5A, 0, 0);
        xfer(8'hF0, 0, 0);
        xfer(8'h6B, 0, 0);

        send_bits(frame_bits(8'h2D, 0, 0), 0, 4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        m_keys = '0;
        m_code = '0;
        m_ext = 0;
        m_brk = 0;
        chk("midrst_keys", keys, 0);
        chk("midrst_code", scan_code, 0);
        chk("midrst_pulses", {scan_valid, frame_err}, 0);
        sv0 = sv_cnt;
        send_bits(frame_bits(8'h2D, 0, 0), 4, 11);
        ps2_data = 1'b1;
        tick(150);
        chk("midrst_trailing_sv", sv_cnt - sv0, 0);
        xfer(8'h2D, 0, 0);

        for (int i = 0; i < 180; i++) begin
            b = ($urandom_range(0, 11) < 10) ? pool[$urandom_range(0, 9)] : 8'($urandom);
            xfer(b, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
        end

        chk("valid_err_overlap", both_cnt, 0);
        chk("pulse_width", wide_cnt, 0);
        chk("key_change_without_valid", stray_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
